alu_share_arb: RTL and testbench

//  Shares the single execute-stage ALU between two requesters: port A (main pipeline) and port B (auxiliary: address-gen/debug).

---
 rtl/alu_share_arb_if.sv | 53 +++++
 rtl/alu_share_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_share_arb.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// Bus bundle for alu_share_arb: two requester channels, the ALU drive/return
// signals and the response channel. "slave" is the arbiter's view and
// "master" is the surrounding logic's view: the requesters, the ALU and the
// response consumer.
interface alu_share_arb_if;
   // requester A
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_op;
   logic [31:0] a_src1;
   logic [31:0] a_src2;
   // requester B
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_op;
   logic [31:0] b_src1;
   logic [31:0] b_src2;
   // shared ALU
   logic [4:0]  alu_op_e;
   logic [31:0] reg_readdata1_e;
   logic [31:0] alumul_data2;
   logic        alu_en_e;
   logic [31:0] alu_out;
   logic        pc_branch_en_sel;
   // response channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_branch;

   modport slave (
      input  a_valid, a_op, a_src1, a_src2,
      output a_ready,
      input  b_valid, b_op, b_src1, b_src2,
      output b_ready,
      output alu_op_e, reg_readdata1_e, alumul_data2, alu_en_e,
      input  alu_out, pc_branch_en_sel,
      output rsp_valid, rsp_id, rsp_data, rsp_branch,
      input  rsp_ready
   );

   modport master (
      output a_valid, a_op, a_src1, a_src2,
      input  a_ready,
      output b_valid, b_op, b_src1, b_src2,
      input  b_ready,
      input  alu_op_e, reg_readdata1_e, alumul_data2, alu_en_e,
      output alu_out, pc_branch_en_sel,
      input  rsp_valid, rsp_id, rsp_data, rsp_branch,
      output rsp_ready
   );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one execute-stage ALU between requester A (main
// pipeline) and requester B (address-gen/debug). One op is in flight at a
// time: grant (T0) -> ALU sees registered operands (T1) -> response held
// from T2 until the consumer takes it. Results the issued op does not
// define are masked to zero.
module alu_share_arb #(
   parameter int PRIO_MODE  = 0,   // 0 = round-robin, 1 = fixed priority to A with starvation guard
   parameter int STARVE_MAX = 8    // fixed mode: cycles B may wait before it is force-granted (1..255)
) (
   input  logic            clk,
   input  logic            rst,
   alu_share_arb_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   // Data result is only defined for the arithmetic/logic ops 1..22.
   function automatic logic [31:0] mask_data(input logic [4:0] op, input logic [31:0] data);
      if ((op >= 5'd1) && (op <= 5'd22)) begin
         return data;
      end else begin
         return 32'd0;
      end
   endfunction

   // The ALU branch flag is sticky, so it is only trusted for branch ops 23..31.
   function automatic logic mask_branch(input logic [4:0] op, input logic flag);
      if (op >= 5'd23) begin
         return flag;
      end else begin
         return 1'b0;
      end
   endfunction

   state_t      state_q, state_d;
   logic        rr_ptr_q, rr_ptr_d;       // 1 = B preferred on the next contested grant
   logic [7:0]  starve_q, starve_d;
   logic [4:0]  alu_op_q, alu_op_d;
   logic [31:0] src1_q, src1_d;
   logic [31:0] src2_q, src2_d;
   logic        id_q, id_d;               // requester of the op currently in the ALU
   logic        alu_en_q, alu_en_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_branch_q, rsp_branch_d;

   logic        window_s;
   logic        grant_a_s;
   logic        grant_b_s;
   logic        grant_s;

   // Grant decision: a new op may start when idle, or when the held response leaves this cycle.
   always_comb begin
      window_s  = 1'b0;
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (rst) begin
         window_s = 1'b0;
      end else if (state_q == ST_IDLE) begin
         window_s = 1'b1;
      end else if (state_q == ST_RESP) begin
         window_s = bus.rsp_ready;
      end else begin
         window_s = 1'b0;
      end

      if (!window_s) begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end else if (PRIO_MODE == 0) begin
         if (bus.a_valid && bus.b_valid) begin
            grant_a_s = !rr_ptr_q;
            grant_b_s = rr_ptr_q;
         end else if (bus.a_valid) begin
            grant_a_s = 1'b1;
         end else if (bus.b_valid) begin
            grant_b_s = 1'b1;
         end else begin
            grant_a_s = 1'b0;
         end
      end else begin
         if (bus.b_valid && (starve_q == STARVE_LIM)) begin
            grant_b_s = 1'b1;
         end else if (bus.a_valid) begin
            grant_a_s = 1'b1;
         end else if (bus.b_valid) begin
            grant_b_s = 1'b1;
         end else begin
            grant_a_s = 1'b0;
         end
      end
   end

   assign grant_s    = grant_a_s | grant_b_s;
   assign bus.a_ready = grant_a_s;
   assign bus.b_ready = grant_b_s;

   // Next-state: FSM sequencing, operand latch on grant, response capture at the end of EXEC.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      starve_d     = starve_q;
      alu_op_d     = alu_op_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      id_d         = id_q;
      alu_en_d     = grant_s;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_branch_d = rsp_branch_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_s) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id_q;
            rsp_data_d   = mask_data(alu_op_q, bus.alu_out);
            rsp_branch_d = mask_branch(alu_op_q, bus.pc_branch_en_sel);
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (grant_s) begin
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      // Operands only move on a grant so the ALU inputs stay quiet while idle.
      if (grant_b_s) begin
         alu_op_d = bus.b_op;
         src1_d   = bus.b_src1;
         src2_d   = bus.b_src2;
         id_d     = 1'b1;
         rr_ptr_d = 1'b0;
      end else if (grant_a_s) begin
         alu_op_d = bus.a_op;
         src1_d   = bus.a_src1;
         src2_d   = bus.a_src2;
         id_d     = 1'b0;
         rr_ptr_d = 1'b1;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end

      // Starvation counter counts every cycle B waits, whatever the FSM is doing.
      if (PRIO_MODE == 0) begin
         starve_d = 8'd0;
      end else if (!bus.b_valid || grant_b_s) begin
         starve_d = 8'd0;
      end else if (starve_q != STARVE_LIM) begin
         starve_d = starve_q + 8'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // State register; reset drops any in-flight op without a response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= 1'b0;
         starve_q     <= 8'd0;
         alu_op_q     <= 5'd0;
         src1_q       <= 32'd0;
         src2_q       <= 32'd0;
         id_q         <= 1'b0;
         alu_en_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= 32'd0;
         rsp_branch_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         starve_q     <= starve_d;
         alu_op_q     <= alu_op_d;
         src1_q       <= src1_d;
         src2_q       <= src2_d;
         id_q         <= id_d;
         alu_en_q     <= alu_en_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_branch_q <= rsp_branch_d;
      end
   end

   assign bus.alu_op_e        = alu_op_q;
   assign bus.reg_readdata1_e = src1_q;
   assign bus.alumul_data2    = src2_q;
   assign bus.alu_en_e        = alu_en_q;
   assign bus.rsp_valid       = rsp_valid_q;
   assign bus.rsp_id          = rsp_id_q;
   assign bus.rsp_data        = rsp_data_q;
   assign bus.rsp_branch      = rsp_branch_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: a round-robin instance and a fixed-priority
// instance (STARVE_MAX=8), each with a small stand-in ALU whose branch flag
// is sticky across non-branch ops.
module tb_alu_share_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   alu_share_arb_if if_rr ();
   alu_share_arb_if if_fx ();

   alu_share_arb #(.PRIO_MODE(0), .STARVE_MAX(8)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
   alu_share_arb #(.PRIO_MODE(1), .STARVE_MAX(8)) u_fx (.clk(clk), .rst(rst), .bus(if_fx.slave));

   // Stand-in ALU: 1 = add, 2 = sub, others = (x ^ y) + op.
   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      case (op)
         5'd1:    return x + y;
         5'd2:    return x - y;
         default: return (x ^ y) + {27'd0, op};
      endcase
   endfunction

   // Stand-in branch condition: taken when (x == y) for odd ops, (x != y) for even ops.
   function automatic logic br_fn(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      return (x == y) ^ ~op[0];
   endfunction

   logic sticky_rr, sticky_fx;

   assign if_rr.alu_out = alu_fn(if_rr.alu_op_e, if_rr.reg_readdata1_e, if_rr.alumul_data2);
   assign if_fx.alu_out = alu_fn(if_fx.alu_op_e, if_fx.reg_readdata1_e, if_fx.alumul_data2);
   assign if_rr.pc_branch_en_sel = (if_rr.alu_op_e >= 5'd23) ?
      br_fn(if_rr.alu_op_e, if_rr.reg_readdata1_e, if_rr.alumul_data2) : sticky_rr;
   assign if_fx.pc_branch_en_sel = (if_fx.alu_op_e >= 5'd23) ?
      br_fn(if_fx.alu_op_e, if_fx.reg_readdata1_e, if_fx.alumul_data2) : sticky_fx;

   // The ALU's branch flag keeps its last branch outcome through non-branch ops.
   always @(posedge clk) begin
      if (rst) begin
         sticky_rr <= 1'b0;
         sticky_fx <= 1'b0;
      end else begin
         if (if_rr.alu_en_e && (if_rr.alu_op_e >= 5'd23))
            sticky_rr <= br_fn(if_rr.alu_op_e, if_rr.reg_readdata1_e, if_rr.alumul_data2);
         if (if_fx.alu_en_e && (if_fx.alu_op_e >= 5'd23))
            sticky_fx <= br_fn(if_fx.alu_op_e, if_fx.reg_readdata1_e, if_fx.alumul_data2);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_a_ready"},   32'(if_rr.a_ready),         32'd0);
      chk({tag, "_b_ready"},   32'(if_rr.b_ready),         32'd0);
      chk({tag, "_alu_op"},    32'(if_rr.alu_op_e),        32'd0);
      chk({tag, "_src1"},      if_rr.reg_readdata1_e,      32'd0);
      chk({tag, "_src2"},      if_rr.alumul_data2,         32'd0);
      chk({tag, "_alu_en"},    32'(if_rr.alu_en_e),        32'd0);
      chk({tag, "_rsp_valid"}, 32'(if_rr.rsp_valid),       32'd0);
      chk({tag, "_rsp_id"},    32'(if_rr.rsp_id),          32'd0);
      chk({tag, "_rsp_data"},  if_rr.rsp_data,             32'd0);
      chk({tag, "_rsp_br"},    32'(if_rr.rsp_branch),      32'd0);
   endtask

   typedef struct {
      logic        side;      // 0 = A, 1 = B
      logic [4:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] exp_data;
      logic        exp_br;
   } vec_t;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        br;
   } rsp_t;

   // One op through the round-robin instance with the consumer always ready.
   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      if (v.side == 1'b0) begin
         if_rr.a_valid = 1'b1; if_rr.a_op = v.op; if_rr.a_src1 = v.s1; if_rr.a_src2 = v.s2;
      end else begin
         if_rr.b_valid = 1'b1; if_rr.b_op = v.op; if_rr.b_src1 = v.s1; if_rr.b_src2 = v.s2;
      end
      #1;
      chk($sformatf("vec%0d_ready", idx), 32'(v.side ? if_rr.b_ready : if_rr.a_ready), 32'd1);
      @(posedge clk); #1;
      if_rr.a_valid = 1'b0;
      if_rr.b_valid = 1'b0;
      chk($sformatf("vec%0d_alu_en_t1", idx), 32'(if_rr.alu_en_e), 32'd1);
      chk($sformatf("vec%0d_rsp_valid_t1", idx), 32'(if_rr.rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rsp_valid_t2", idx), 32'(if_rr.rsp_valid), 32'd1);
      chk($sformatf("vec%0d_rsp_id", idx), 32'(if_rr.rsp_id), 32'(v.side));
      chk($sformatf("vec%0d_rsp_data", idx), if_rr.rsp_data, v.exp_data);
      chk($sformatf("vec%0d_rsp_br", idx), 32'(if_rr.rsp_branch), 32'(v.exp_br));
      @(posedge clk);
   endtask

   vec_t vecs [10];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t v;
      rsp_t exp_q [$];
      rsp_t r;
      int   k, cyc, g1, g2, nb, last_a;
      logic exec_m, held_m, last_b_m, window_m, exp_a, exp_b;
      logic a_pend, b_pend;

      vecs[0] = '{1'b0, 5'd1,  32'd5,    32'd7,    32'd12,    1'b0};
      vecs[1] = '{1'b0, 5'd2,  32'd10,   32'd3,    32'd7,     1'b0};
      vecs[2] = '{1'b1, 5'd23, 32'd5,    32'd5,    32'd0,     1'b1};
      vecs[3] = '{1'b0, 5'd1,  32'd1,    32'd1,    32'd2,     1'b0};  // sticky flag still 1 here
      vecs[4] = '{1'b0, 5'd0,  32'd3,    32'd4,    32'd0,     1'b0};
      vecs[5] = '{1'b1, 5'd22, 32'h0F0,  32'h00F,  32'h115,   1'b0};
      vecs[6] = '{1'b0, 5'd24, 32'd5,    32'd6,    32'd0,     1'b1};
      vecs[7] = '{1'b1, 5'd31, 32'd9,    32'd9,    32'd0,     1'b1};
      vecs[8] = '{1'b0, 5'd25, 32'd1,    32'd2,    32'd0,     1'b0};
      vecs[9] = '{1'b1, 5'd5,  32'd2,    32'd3,    32'd6,     1'b0};

      if_rr.a_valid = 1'b1; if_rr.a_op = 5'd1; if_rr.a_src1 = 32'd1; if_rr.a_src2 = 32'd2;
      if_rr.b_valid = 1'b1; if_rr.b_op = 5'd1; if_rr.b_src1 = 32'd3; if_rr.b_src2 = 32'd4;
      if_rr.rsp_ready = 1'b1;
      if_fx.a_valid = 1'b0; if_fx.a_op = 5'd0; if_fx.a_src1 = 32'd0; if_fx.a_src2 = 32'd0;
      if_fx.b_valid = 1'b0; if_fx.b_op = 5'd0; if_fx.b_src1 = 32'd0; if_fx.b_src2 = 32'd0;
      if_fx.rsp_ready = 1'b1;

      // Reset held with both requesters valid: nothing may be granted.
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      if_rr.a_valid = 1'b0;
      if_rr.b_valid = 1'b0;
      rst = 1'b0;

      // Table-driven single-op vectors, including masking and the sticky flag.
      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Backpressure: response held 5 cycles, then release grants B in the same cycle.
      do_reset();
      @(negedge clk);
      if_rr.rsp_ready = 1'b0;
      if_rr.a_valid = 1'b1; if_rr.a_op = 5'd1; if_rr.a_src1 = 32'd5; if_rr.a_src2 = 32'd7;
      if_rr.b_valid = 1'b1; if_rr.b_op = 5'd2; if_rr.b_src1 = 32'd9; if_rr.b_src2 = 32'd4;
      #1;
      chk("bp_first_a_ready", 32'(if_rr.a_ready), 32'd1);
      chk("bp_first_b_ready", 32'(if_rr.b_ready), 32'd0);
      @(posedge clk); #1;
      if_rr.a_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", i), 32'(if_rr.rsp_valid), 32'd1);
         chk($sformatf("bp_hold%0d_data", i), if_rr.rsp_data, 32'd12);
         chk($sformatf("bp_hold%0d_a_ready", i), 32'(if_rr.a_ready), 32'd0);
         chk($sformatf("bp_hold%0d_b_ready", i), 32'(if_rr.b_ready), 32'd0);
      end
      @(negedge clk);
      if_rr.rsp_ready = 1'b1;
      #1;
      chk("bp_release_b_ready", 32'(if_rr.b_ready), 32'd1);
      chk("bp_release_valid", 32'(if_rr.rsp_valid), 32'd1);
      @(posedge clk); #1;
      if_rr.b_valid = 1'b0;
      chk("bp_next_alu_en", 32'(if_rr.alu_en_e), 32'd1);
      chk("bp_next_alu_op", 32'(if_rr.alu_op_e), 32'd2);
      chk("bp_old_rsp_gone", 32'(if_rr.rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk("bp_b_rsp_valid", 32'(if_rr.rsp_valid), 32'd1);
      chk("bp_b_rsp_id", 32'(if_rr.rsp_id), 32'd1);
      chk("bp_b_rsp_data", if_rr.rsp_data, 32'd5);

      // Round-robin with both valid: responses alternate A,B,A,B at one per 2 cycles.
      do_reset();
      @(negedge clk);
      if_rr.a_valid = 1'b1; if_rr.a_op = 5'd1; if_rr.a_src1 = 32'd1;  if_rr.a_src2 = 32'd1;
      if_rr.b_valid = 1'b1; if_rr.b_op = 5'd2; if_rr.b_src1 = 32'd10; if_rr.b_src2 = 32'd1;
      k = 0;
      cyc = 0;
      while ((k < 4) && (cyc < 40)) begin
         #1;
         if (if_rr.rsp_valid) begin
            chk($sformatf("rr_rsp%0d_id", k), 32'(if_rr.rsp_id), 32'(k % 2));
            chk($sformatf("rr_rsp%0d_data", k), if_rr.rsp_data, (k % 2 == 0) ? 32'd2 : 32'd9);
            chk($sformatf("rr_rsp%0d_cycle", k), 32'(cyc), 32'(2 + 2 * k));
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("rr_rsp_count", 32'(k), 32'd4);
      if_rr.a_valid = 1'b0;
      if_rr.b_valid = 1'b0;

      // Reset during EXEC: the op is dropped and never answered.
      do_reset();
      @(negedge clk);
      if_rr.a_valid = 1'b1; if_rr.a_op = 5'd1; if_rr.a_src1 = 32'd5; if_rr.a_src2 = 32'd7;
      @(posedge clk); #1;
      if_rr.a_valid = 1'b0;
      chk("rstexec_alu_en", 32'(if_rr.alu_en_e), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("rstexec");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rstexec_no_rsp%0d", i), 32'(if_rr.rsp_valid), 32'd0);
      end

      // Fixed priority: A always valid, B granted after 8 waiting cycles, then waits again.
      do_reset();
      nb = 0; g1 = -1; g2 = -1; last_a = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) begin
            if_fx.a_valid = 1'b1; if_fx.a_op = 5'd1; if_fx.a_src1 = 32'd1; if_fx.a_src2 = 32'd1;
            if_fx.b_valid = 1'b1; if_fx.b_op = 5'd2; if_fx.b_src1 = 32'd3; if_fx.b_src2 = 32'd1;
         end
         #1;
         chk($sformatf("fx_onehot_c%0d", c), 32'(if_fx.a_ready & if_fx.b_ready), 32'd0);
         if (if_fx.b_ready) begin
            if (nb == 0) g1 = c;
            else if (nb == 1) g2 = c;
            nb++;
         end
         if (if_fx.a_ready && (nb == 1) && (last_a < 0)) last_a = c;
      end
      chk("fx_first_b_grant_cycle", 32'(g1), 32'd8);
      chk("fx_a_after_b_cycle", 32'(last_a), 32'd10);
      // Counter restarts after the grant at cycle 8 and counts from cycle 9, so B waits 9..17.
      chk("fx_second_b_grant_cycle", 32'(g2), 32'd18);
      if_fx.a_valid = 1'b0;
      if_fx.b_valid = 1'b0;

      // Randomized traffic on the round-robin instance against a transaction-level model.
      do_reset();
      exec_m = 1'b0; held_m = 1'b0; last_b_m = 1'b1;
      a_pend = 1'b0; b_pend = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!a_pend) begin
            if_rr.a_valid = ($urandom_range(0, 2) != 0);
            if_rr.a_op    = 5'($urandom_range(0, 31));
            if_rr.a_src1  = 32'($urandom_range(0, 15));
            if_rr.a_src2  = ($urandom_range(0, 3) == 0) ? if_rr.a_src1 : 32'($urandom);
         end
         if (!b_pend) begin
            if_rr.b_valid = ($urandom_range(0, 2) != 0);
            if_rr.b_op    = 5'($urandom_range(0, 31));
            if_rr.b_src1  = 32'($urandom);
            if_rr.b_src2  = ($urandom_range(0, 3) == 0) ? if_rr.b_src1 : 32'($urandom_range(0, 15));
         end
         if_rr.rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         window_m = !exec_m && (!held_m || if_rr.rsp_ready);
         exp_a = 1'b0;
         exp_b = 1'b0;
         if (window_m) begin
            if (if_rr.a_valid && if_rr.b_valid) begin
               exp_a = last_b_m;
               exp_b = !last_b_m;
            end else begin
               exp_a = if_rr.a_valid;
               exp_b = if_rr.b_valid;
            end
         end
         chk($sformatf("rnd_c%0d_a_ready", c), 32'(if_rr.a_ready), 32'(exp_a));
         chk($sformatf("rnd_c%0d_b_ready", c), 32'(if_rr.b_ready), 32'(exp_b));
         chk($sformatf("rnd_c%0d_alu_en", c), 32'(if_rr.alu_en_e), 32'(exec_m));
         chk($sformatf("rnd_c%0d_rsp_valid", c), 32'(if_rr.rsp_valid), 32'(held_m));
         if (held_m && (exp_q.size() > 0)) begin
            chk($sformatf("rnd_c%0d_rsp_id", c), 32'(if_rr.rsp_id), 32'(exp_q[0].id));
            chk($sformatf("rnd_c%0d_rsp_data", c), if_rr.rsp_data, exp_q[0].data);
            chk($sformatf("rnd_c%0d_rsp_br", c), 32'(if_rr.rsp_branch), 32'(exp_q[0].br));
         end
         // Model advances by one clock edge.
         if (held_m && if_rr.rsp_ready) begin
            void'(exp_q.pop_front());
            held_m = 1'b0;
         end
         if (exec_m) begin
            held_m = 1'b1;
            exec_m = 1'b0;
         end
         if (exp_a || exp_b) begin
            r.id = exp_b;
            v.op = exp_b ? if_rr.b_op : if_rr.a_op;
            v.s1 = exp_b ? if_rr.b_src1 : if_rr.a_src1;
            v.s2 = exp_b ? if_rr.b_src2 : if_rr.a_src2;
            r.data = ((v.op >= 5'd1) && (v.op <= 5'd22)) ? alu_fn(v.op, v.s1, v.s2) : 32'd0;
            r.br   = (v.op >= 5'd23) ? br_fn(v.op, v.s1, v.s2) : 1'b0;
            exp_q.push_back(r);
            exec_m   = 1'b1;
            last_b_m = exp_b;
         end
         a_pend = if_rr.a_valid && !if_rr.a_ready;
         b_pend = if_rr.b_valid && !if_rr.b_ready;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
